// File: rtl/bootcopy_pkg.sv
// ============================================================================
// bootcopy_pkg : shared types and AHB-Lite encodings for the boot copy engine.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package bootcopy_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Counter must be able to hold WORDS itself; never narrower than one bit.
  function automatic int cnt_bits(input int words);
    return (words < 1) ? 1 : $clog2(words + 1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/config_pkg.sv
// ============================================================================
// config_pkg : SoC-wide configuration (data width, physical address width,
//              boot ROM location).
// Revision   : 1.0
// ============================================================================
`default_nettype none

package config_pkg;
  localparam int XLEN    = 64;
  localparam int PA_BITS = 32;
  localparam logic [PA_BITS-1:0] BOOTROM_BASE = 32'h0000_1000;
endpackage

`default_nettype wire

// File: rtl/bootcopy_addrgen.sv
// ============================================================================
// bootcopy_addrgen : word counter with source/destination address adders and
//                    a last-word flag for the boot copy engine.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module bootcopy_addrgen
  import config_pkg::*;
  import bootcopy_pkg::*;
#(
  parameter logic [PA_BITS-1:0] SRC_BASE = BOOTROM_BASE,
  parameter logic [PA_BITS-1:0] DST_BASE = 32'h8000_0000,
  parameter int                 WORDS    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [PA_BITS-1:0] src_addr,
  output logic [PA_BITS-1:0] dst_addr,
  output logic               last_word
);

  localparam int CNT_W   = cnt_bits(WORDS);
  localparam int BYTE_SH = $clog2(XLEN / 8);
  localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(WORDS);

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [PA_BITS-1:0] offset;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Byte offset wraps with the address space.
  assign offset    = PA_BITS'(cnt_q) << BYTE_SH;
  assign src_addr  = SRC_BASE + offset;
  assign dst_addr  = DST_BASE + offset;
  assign last_word = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) == LAST_CNT;

endmodule

`default_nettype wire

// File: rtl/boot_copy_ahb.sv
// ============================================================================
// boot_copy_ahb : AHB-Lite manager copying WORDS words from boot ROM to RAM.
//                 Optional running checksum under BOOTCOPY_CHECKSUM_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module boot_copy_ahb
  import config_pkg::*;
  import bootcopy_pkg::*;
#(
  parameter logic [PA_BITS-1:0] SRC_BASE   = BOOTROM_BASE,
  parameter logic [PA_BITS-1:0] DST_BASE   = 32'h8000_0000,
  parameter int                 WORDS      = 1024,
  parameter bit                 AUTO_START = 1'b1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               Start,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [XLEN-1:0]    HWDATA,
  input  logic [XLEN-1:0]    HRDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [XLEN-1:0]    Checksum
);

  state_t             state_q, state_d;
  logic               auto_q, auto_d;
  logic [PA_BITS-1:0] haddr_q;
  logic [XLEN-1:0]    data_q, data_d;
  logic [XLEN-1:0]    hwdata_q, hwdata_d;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               rd_cap;
  logic [PA_BITS-1:0] src_addr;
  logic [PA_BITS-1:0] dst_addr;
  logic               last_word;

  bootcopy_addrgen #(
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .WORDS    (WORDS)
  ) u_addrgen (
    .clk       (HCLK),
    .rst       (HRESET),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .last_word (last_word)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      auto_q   <= AUTO_START;
      haddr_q  <= '0;
      data_q   <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      haddr_q  <= HADDR;
      data_q   <= data_d;
      hwdata_q <= hwdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    auto_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    rd_cap   = 1'b0;
    data_d   = data_q;
    hwdata_d = hwdata_q;
    HADDR    = haddr_q;
    HTRANS   = HTRANS_IDLE;
    HWRITE   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        // auto_q is only set during the first cycle after reset, when in IDLE.
        if (Start || auto_q) begin
          cnt_clr = 1'b1;
          state_d = (WORDS == 0) ? DONE : RD_A;
        end
      end
      RD_A: begin
        HADDR  = src_addr;
        HTRANS = HTRANS_NONSEQ;
        if (HREADY) state_d = RD_D;
      end
      RD_D: begin
        if (HRESP) begin
          state_d = ERR;
        end else if (HREADY) begin
          rd_cap  = 1'b1;
          data_d  = HRDATA;
          state_d = WR_A;
        end
      end
      WR_A: begin
        HADDR  = dst_addr;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
        if (HREADY) begin
          hwdata_d = data_q;
          state_d  = WR_D;
        end
      end
      WR_D: begin
        if (HRESP) begin
          state_d = ERR;
        end else if (HREADY) begin
          cnt_inc = 1'b1;
          state_d = last_word ? DONE : RD_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BOOTCOPY_CHECKSUM_EN
  logic [XLEN-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (cnt_clr) begin
      cks_d = '0;
    end else if (rd_cap) begin
      cks_d = cks_q + HRDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign Checksum = cks_q;
`else
  assign Checksum = '0;
`endif

  assign HWDATA = hwdata_q;
  assign HSIZE  = 3'($clog2(XLEN / 8));
  assign HBURST = HBURST_SINGLE;
  assign Busy   = (state_q == RD_A) || (state_q == RD_D) ||
                  (state_q == WR_A) || (state_q == WR_D);
  assign Done   = (state_q == DONE);
  assign Err    = (state_q == ERR);

endmodule

`default_nettype wire

// File: tb/tb_boot_copy_ahb.sv
// ============================================================================
// tb_boot_copy_ahb : self-checking bench for boot_copy_ahb with an AHB-Lite
//                    ROM/RAM model and a transfer scoreboard.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_boot_copy_ahb;
  import config_pkg::*;

  localparam int NW = 4;
  localparam logic [PA_BITS-1:0] SRC = 32'h0000_1000;
  localparam logic [PA_BITS-1:0] DST = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               HRESET = 1'b1;
  logic               Start  = 1'b0;
  logic [PA_BITS-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE, HBURST;
  logic [XLEN-1:0]    HWDATA, Checksum;
  logic [XLEN-1:0]    HRDATA = '0;
  logic               HREADY = 1'b1;
  logic               HRESP  = 1'b0;
  logic               Busy, Done, Err;

  logic [PA_BITS-1:0] HADDR_z;
  logic [1:0]         HTRANS_z;
  logic               HWRITE_z, Busy_z, Done_z, Err_z;
  logic [2:0]         HSIZE_z, HBURST_z;
  logic [XLEN-1:0]    HWDATA_z, Checksum_z;

  boot_copy_ahb #(
    .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(NW), .AUTO_START(1'b1)
  ) dut (
    .HCLK(clk), .HRESET(HRESET), .Start(Start),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .Busy(Busy), .Done(Done), .Err(Err), .Checksum(Checksum)
  );

  boot_copy_ahb #(
    .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(0), .AUTO_START(1'b1)
  ) dut_z (
    .HCLK(clk), .HRESET(HRESET), .Start(1'b0),
    .HADDR(HADDR_z), .HTRANS(HTRANS_z), .HWRITE(HWRITE_z), .HSIZE(HSIZE_z),
    .HBURST(HBURST_z), .HWDATA(HWDATA_z), .HRDATA('0), .HREADY(1'b1),
    .HRESP(1'b0), .Busy(Busy_z), .Done(Done_z), .Err(Err_z), .Checksum(Checksum_z)
  );

  typedef struct {
    bit                 wr;
    logic [PA_BITS-1:0] addr;
    logic [XLEN-1:0]    data;
  } xfer_t;

  typedef struct {
    int stall_idx;
    int stall_cyc;
    int err_idx;
    int exp_n;
    bit exp_done;
    bit exp_err;
    int busy_at;
  } scen_t;

  xfer_t           sb[$];
  xfer_t           e;
  logic [XLEN-1:0] rom [NW];
  int n_cmp = 0;
  int n_bad = 0;

  // Bus model state
  bit                 dp_valid = 1'b0;
  bit                 dp_write = 1'b0;
  int                 dp_idx = 0;
  logic [XLEN-1:0]    dp_data = '0;
  int                 stall_idx = -1;
  int                 stall_left = 0;
  int                 err_idx = -1;
  int                 err_stage = 0;
  bit                 stall_prev = 1'b0;
  logic [PA_BITS-1:0] sv_addr = '0;
  logic               sv_write = 1'b0;
  int                 bad_z = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [PA_BITS-1:0] a, input logic [PA_BITS-1:0] base);
    return int'((a - base) >> 3);
  endfunction

  // Responses for the current cycle are decided mid-cycle from stable DUT outputs.
  always @(negedge clk) begin
    if (HTRANS_z !== 2'b00) bad_z++;
    if (HRESET) begin
      dp_valid   = 1'b0;
      stall_prev = 1'b0;
      err_stage  = 0;
      HREADY     = 1'b1;
      HRESP      = 1'b0;
      HRDATA     = '0;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp_valid && dp_write && dp_idx == err_idx) begin
        if (err_stage == 0) begin
          HREADY    = 1'b0;
          HRESP     = 1'b1;
          err_stage = 1;
        end else begin
          HRESP     = 1'b1;
          err_stage = 0;
          err_idx   = -1;
        end
      end else if (HTRANS == 2'b10 && HWRITE && widx(HADDR, DST) == stall_idx && stall_left > 0) begin
        HREADY = 1'b0;
        stall_left--;
      end
      HRDATA = (dp_valid && !dp_write && dp_idx < NW) ? rom[dp_idx] : '0;

      if (stall_prev) begin
        chk("stall_haddr", 64'(HADDR), 64'(sv_addr));
        chk("stall_htrans", 64'(HTRANS), 64'(2'b10));
        chk("stall_hwrite", 64'(HWRITE), 64'(sv_write));
      end
      stall_prev = (HTRANS == 2'b10) && !HREADY;
      sv_addr    = HADDR;
      sv_write   = HWRITE;

      if (dp_valid && HREADY && !HRESP && dp_write)
        chk("hwdata", HWDATA, dp_data);

      if (HTRANS == 2'b10 && HREADY) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got addr %0h write %0b, expected no transfer", HADDR, HWRITE);
          dp_valid = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("hwrite", 64'(HWRITE), 64'(e.wr));
          chk("haddr", 64'(HADDR), 64'(e.addr));
          dp_valid = 1'b1;
          dp_write = HWRITE;
          dp_idx   = HWRITE ? widx(HADDR, DST) : widx(HADDR, SRC);
          dp_data  = e.data;
        end
      end else if (!(dp_valid && !HREADY)) begin
        dp_valid = 1'b0;
      end
    end
  end

  task automatic push_copy(input int err_at);
    for (int w = 0; w < NW; w++) begin
      sb.push_back('{wr: 1'b0, addr: SRC + PA_BITS'(w * 8), data: '0});
      sb.push_back('{wr: 1'b1, addr: DST + PA_BITS'(w * 8), data: rom[w]});
      if (w == err_at) break;
    end
  endtask

  // Counts edges after the start edge until Done or Err is seen.
  task automatic wait_finish(input int busy_at, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (Done || Err) break;
      Start = (n == busy_at);
    end
    Start = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] exp_cks(input int last);
    logic [XLEN-1:0] s;
    s = '0;
`ifdef BOOTCOPY_CHECKSUM_EN
    for (int w = 0; w <= last; w++) s = s + rom[w];
`endif
    return s;
  endfunction

  scen_t tbl [4];
  int    n;

  initial begin
    for (int w = 0; w < NW; w++) rom[w] = 64'h11 * 64'(w + 1);
    tbl[0] = '{-1, 0, -1, 16, 1'b1, 1'b0, 0};  // re-copy from DONE
    tbl[1] = '{ 1, 3, -1, 19, 1'b1, 1'b0, 0};  // write address stall on word 1
    tbl[2] = '{-1, 0,  2, 12, 1'b0, 1'b1, 0};  // error on write of word 2
    tbl[3] = '{-1, 0, -1, 16, 1'b1, 1'b0, 6};  // retry from ERR, Start while busy

    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", 64'(HTRANS), 64'(2'b00));
    chk("rst_hwrite", 64'(HWRITE), 64'(1'b0));
    chk("rst_haddr", 64'(HADDR), 64'(0));
    chk("rst_hwdata", HWDATA, 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_err", 64'(Err), 64'(0));
    chk("rst_checksum", Checksum, 64'(0));
    chk("rst_done_z", 64'(Done_z), 64'(0));
    chk("hsize", 64'(HSIZE), 64'(3));
    chk("hburst", 64'(HBURST), 64'(0));

    // Auto start right after reset release
    push_copy(-1);
    HRESET = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("auto_busy", 64'(Busy), 64'(1));
    chk("words0_done", 64'(Done_z), 64'(1));
    wait_finish(0, n);
    chk("auto_cycles", 64'(n), 64'(16));
    chk("auto_done", 64'(Done), 64'(1));
    chk("auto_checksum", Checksum, exp_cks(NW - 1));
    chk("auto_sb_drained", 64'(sb.size()), 64'(0));

    for (int i = 0; i < 4; i++) begin
      stall_idx  = tbl[i].stall_idx;
      stall_left = tbl[i].stall_cyc;
      err_idx    = tbl[i].err_idx;
      err_stage  = 0;
      push_copy(tbl[i].err_idx);
      @(posedge clk);
      #1 Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      wait_finish(tbl[i].busy_at, n);
      chk($sformatf("s%0d_cycles", i), 64'(n), 64'(tbl[i].exp_n));
      chk($sformatf("s%0d_done", i), 64'(Done), 64'(tbl[i].exp_done));
      chk($sformatf("s%0d_err", i), 64'(Err), 64'(tbl[i].exp_err));
      chk($sformatf("s%0d_busy", i), 64'(Busy), 64'(0));
      chk($sformatf("s%0d_checksum", i), Checksum,
          exp_cks(tbl[i].err_idx >= 0 ? tbl[i].err_idx : NW - 1));
      repeat (5) @(negedge clk);
      chk($sformatf("s%0d_sb_drained", i), 64'(sb.size()), 64'(0));
      chk($sformatf("s%0d_htrans_idle", i), 64'(HTRANS), 64'(2'b00));
    end

    // Reset asserted during RD_D of word 1, then auto restart from word 0
    push_copy(-1);
    @(posedge clk);
    #1 Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy_before", 64'(Busy), 64'(1));
    chk("mid_haddr_hold", 64'(HADDR), 64'(SRC + 32'h8));
    HRESET = 1'b1;
    #1;
    chk("mid_htrans", 64'(HTRANS), 64'(2'b00));
    chk("mid_busy", 64'(Busy), 64'(0));
    chk("mid_haddr", 64'(HADDR), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    push_copy(-1);
    HRESET = 1'b0;
    @(posedge clk);
    wait_finish(0, n);
    chk("restart_cycles", 64'(n), 64'(16));
    chk("restart_done", 64'(Done), 64'(1));
    chk("restart_checksum", Checksum, exp_cks(NW - 1));
    repeat (3) @(negedge clk);
    chk("restart_sb_drained", 64'(sb.size()), 64'(0));
    chk("words0_htrans_idle", 64'(bad_z), 64'(0));
    chk("words0_done_final", 64'(Done_z), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
